// File: rtl/ex_alu_dpath_seq_pkg.sv
// Shared widths, op-vector bit positions and FSM encodings for the sequential ALU datapath.
package ex_alu_dpath_seq_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 11;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_SLL  = 3;
    localparam int OP_SRL  = 4;
    localparam int OP_SRA  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_AND  = 7;
    localparam int OP_SLT  = 8;
    localparam int OP_SLTU = 9;
    localparam int OP_LUI  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } shdir_e;

endpackage

// File: rtl/ex_alu_dpath_seq_comb.sv
// Single-cycle ALU ops and op-vector legality check; shift ops are only flagged here.
module ex_alu_dpath_seq_comb
    import ex_alu_dpath_seq_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN_P-1:0] op1,
    input  logic [XLEN_P-1:0] op2,
    output logic [XLEN_P-1:0] res,
    output logic              err,
    output logic              is_shift
);

    logic              legal;
    logic [XLEN_P-1:0] sum;
    logic [XLEN_P-1:0] diff;
    logic              lt_s;
    logic              lt_u;

    assign legal = $onehot(op);
    assign sum   = op1 + op2;
    assign diff  = op1 - op2;
    assign lt_s  = $signed(op1) < $signed(op2);
    assign lt_u  = op1 < op2;

    always_comb begin
        res      = '0;
        err      = ~legal;
        is_shift = legal & (op[OP_SLL] | op[OP_SRL] | op[OP_SRA]);
        // Illegal vectors fall through with res=0 so the top can report them directly.
        if (legal) begin
            res = ({XLEN_P{op[OP_ADD]}}  & sum)
                | ({XLEN_P{op[OP_SUB]}}  & diff)
                | ({XLEN_P{op[OP_XOR]}}  & (op1 ^ op2))
                | ({XLEN_P{op[OP_OR]}}   & (op1 | op2))
                | ({XLEN_P{op[OP_AND]}}  & (op1 & op2))
                | ({XLEN_P{op[OP_SLT]}}  & {{(XLEN_P-1){1'b0}}, lt_s})
                | ({XLEN_P{op[OP_SLTU]}} & {{(XLEN_P-1){1'b0}}, lt_u})
                | ({XLEN_P{op[OP_LUI]}}  & op2);
        end
    end

endmodule

// File: rtl/ex_alu_dpath_seq.sv
// Sequential ALU datapath responder: 1-cycle ops via the comb block, shifts at one bit per cycle.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_SHIFT | iterating a shift, one bit per clock
//   ST_DONE  | result held until rsp_ready
module ex_alu_dpath_seq
    import ex_alu_dpath_seq_pkg::*;
#(
    parameter int XLEN    = ex_alu_dpath_seq_pkg::XLEN,
    parameter int SHAMT_W = ex_alu_dpath_seq_pkg::SHAMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [XLEN-1:0]  req_op1,
    input  logic [XLEN-1:0]  req_op2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_res,
    output logic             rsp_err
);

    state_e             state_q, state_d;
    shdir_e             dir_q, dir_d;
    logic               fill_q, fill_d;
    logic [XLEN-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               err_q, err_d;

    logic [XLEN-1:0]    comb_res;
    logic               comb_err;
    logic               comb_is_shift;
    logic [XLEN-1:0]    acc_step;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;

    ex_alu_dpath_seq_comb #(.XLEN_P(XLEN)) u_comb (
        .op       (req_op),
        .op1      (req_op1),
        .op2      (req_op2),
        .res      (comb_res),
        .err      (comb_err),
        .is_shift (comb_is_shift)
    );

    assign req_ready = (state_q == ST_IDLE) & ~rst;
    // A reset cycle must not let the consumer complete a handshake on a discarded op.
    assign rsp_valid = (state_q == ST_DONE) & ~rst;
    assign rsp_res   = res_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid & req_ready;
    assign shamt     = req_op2[SHAMT_W-1:0];
    assign acc_step  = (dir_q == SH_LEFT) ? {acc_q[XLEN-2:0], 1'b0}
                                          : {fill_q, acc_q[XLEN-1:1]};

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (comb_is_shift) begin
                        // sra replicates the captured sign; srl and sll shift in zeros.
                        dir_d  = req_op[OP_SLL] ? SH_LEFT : SH_RIGHT;
                        fill_d = req_op[OP_SRA] & req_op1[XLEN-1];
                        acc_d  = req_op1;
                        cnt_d  = shamt;
                        err_d  = 1'b0;
                        if (shamt == '0) begin
                            res_d   = req_op1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        res_d   = comb_res;
                        err_d   = comb_err;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    res_d   = acc_step;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= SH_LEFT;
            fill_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ex_alu_dpath_seq.sv
// Directed bench for ex_alu_dpath_seq with an expected-result queue popped on each response.
module tb_ex_alu_dpath_seq;

    localparam logic [10:0] OP_ADD  = 11'b000_0000_0001;
    localparam logic [10:0] OP_SUB  = 11'b000_0000_0010;
    localparam logic [10:0] OP_XOR  = 11'b000_0000_0100;
    localparam logic [10:0] OP_SLL  = 11'b000_0000_1000;
    localparam logic [10:0] OP_SRL  = 11'b000_0001_0000;
    localparam logic [10:0] OP_SRA  = 11'b000_0010_0000;
    localparam logic [10:0] OP_OR   = 11'b000_0100_0000;
    localparam logic [10:0] OP_AND  = 11'b000_1000_0000;
    localparam logic [10:0] OP_SLT  = 11'b001_0000_0000;
    localparam logic [10:0] OP_SLTU = 11'b010_0000_0000;
    localparam logic [10:0] OP_LUI  = 11'b100_0000_0000;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_op;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    ex_alu_dpath_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request at a negedge, accepts on the next posedge, then scrambles the inputs.
    task automatic drive_req(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        check("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = OP_XOR;
        req_op1   = $urandom;
        req_op2   = $urandom;
    endtask

    // Called at the first negedge after the accept edge.
    task automatic wait_rsp(input string tag, input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_lat"},   32'(lat),       32'(e.lat));
        check({tag, "_res"},   rsp_res,        e.res);
        check({tag, "_err"},   32'(rsp_err),   32'(e.err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_op    = OP_ADD;
            req_op1   = 32'd100;
            req_op2   = 32'd200;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_res"},   rsp_res,        e.res);
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_drop_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [10:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic err,
                          input int lat, input int hold);
        exp_t e;
        e.res = res;
        e.err = err;
        e.lat = lat;
        exp_q.push_back(e);
        rsp_ready = (hold == 0);
        drive_req(op, a, b);
        wait_rsp(tag, hold);
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_op1   = '0;
        req_op2   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_res",   rsp_res,        32'd0);
        check("rst_err",   32'(rsp_err),   32'd0);

        run_op("add_wrap", OP_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1, 0);
        run_op("sub_neg",  OP_SUB,  32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1, 0);
        run_op("sra4",     OP_SRA,  32'h8000_0010, 32'h0000_0024, 32'hF800_0001, 1'b0, 5, 0);
        run_op("sll0",     OP_SLL,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1, 0);
        run_op("sll7",     OP_SLL,  32'h0000_00FF, 32'd7, 32'h0000_7F80, 1'b0, 8, 0);
        run_op("sra31pos", OP_SRA,  32'h7FFF_FFFF, 32'd31, 32'h0000_0000, 1'b0, 32, 0);
        run_op("slt",      OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 0);
        run_op("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 0);
        run_op("xor",      OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1, 0);
        run_op("or",       OP_OR,   32'hA000_0005, 32'h0500_0030, 32'hA500_0035, 1'b0, 1, 0);
        run_op("and",      OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1, 0);
        run_op("lui",      OP_LUI,  32'hDEAD_BEEF, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1, 0);
        run_op("srl_bp",   OP_SRL,  32'h0000_00F0, 32'd4, 32'h0000_000F, 1'b0, 5, 6);
        run_op("ill_two",  11'b000_0000_0011, 32'd5, 32'd6, 32'd0, 1'b1, 1, 0);
        run_op("ill_zero", 11'b000_0000_0000, 32'd5, 32'd6, 32'd0, 1'b1, 1, 0);

        // Reset in the middle of a 31-bit shift: no response may ever appear for it.
        rsp_ready = 1'b1;
        drive_req(OP_SLL, 32'd1, 32'd31);
        seen = 1'b0;
        repeat (8) begin
            seen |= rsp_valid;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_in_rst", 32'(req_ready), 32'd0);
        seen |= rsp_valid;
        rst = 1'b0;
        #1;
        check("midrst_ready_after", 32'(req_ready), 32'd1);
        repeat (40) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        check("midrst_no_rsp", 32'(seen), 32'd0);
        run_op("add_after_rst", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_alu_dpath_seq.md
Name: ex_alu_dpath_seq

Overview:
- Responder end of the ALU regular-unit datapath request interface. Accepts one operation at a time: a one-hot op vector plus op1 and op2.
- Computes the result and returns it over a valid/ready response channel.
- Shifts run iteratively at 1 bit per cycle to save area. All other ops complete in 1 cycle.
- Sits between the ALU regular/agu request muxing and the write-back path, in place of the single-cycle combinational shared datapath.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  11  one-hot op select; bit order add, sub, xor, sll, srl, sra, or, and, slt, sltu, lui.
- req_op1  in  XLEN  operand 1 (rs1 or pc, already muxed by requester).
- req_op2  in  XLEN  operand 2 (rs2 or imm, already muxed by requester).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_res  out  XLEN  result.
- rsp_err  out  1  request op vector was not one-hot.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, rsp_valid=0, rsp_res=0, rsp_err=0, internal shift count=0.
- req_ready is 0 on any cycle where rst=1.
- States:
  - IDLE: req_ready=1, rsp_valid=0.
  - SHIFT: req_ready=0, rsp_valid=0.
  - DONE: req_ready=0, rsp_valid=1.
- Accept = req_valid & req_ready, sampled at the edge. op, op1 and op2 are captured at accept; later changes on req_* have no effect.
- IDLE with no accept: stay IDLE, all registers unchanged.
- IDLE, accept, non-shift op: result is written to the result register and the block moves to DONE. rsp_valid goes high 1 cycle after accept.
- IDLE, accept, shift op (sll/srl/sra):
  - acc <= op1, cnt <= op2[SHAMT_W-1:0]; upper op2 bits are ignored.
  - If cnt==0, go straight to DONE with rsp_res=op1.
  - Otherwise go to SHIFT.
- SHIFT:
  - Each edge shifts acc by 1 bit and does cnt <= cnt-1.
  - sll fills 0 at the LSB. srl fills 0 at the MSB. sra fills with the op1[XLEN-1] captured at accept.
  - On the edge where cnt goes 1->0, move to DONE.
  - Latency accept -> rsp_valid = 1 + shamt cycles (max 32).
- DONE:
  - rsp_res and rsp_err stay stable while rsp_valid=1 & rsp_ready=0.
  - On rsp_valid & rsp_ready, go to IDLE and drop rsp_valid the next cycle.
  - No back-to-back accept from DONE. Max throughput is 1 op per 2 cycles.
- Arithmetic rules:
  - add/sub wrap modulo 2^XLEN; no overflow flag.
  - slt is a signed compare; sltu is unsigned. Both give {XLEN-1 zeros, lt}.
  - lui: result = op2; op1 is ignored.
  - xor/or/and are bitwise.
- Error case: req_op is zero or has more than one bit set. The block still accepts, and after 1 cycle enters DONE with rsp_res=0, rsp_err=1. rsp_err=0 for all legal ops.
- rst=1 in any state, including mid-SHIFT or DONE awaiting ready: the in-flight op is discarded with no response. Next cycle the block is in IDLE.
- rsp_ready is don't-care outside DONE.

Decomposition:
- Shared defines go in gen_defines.v:
  - bit-index macros for req_op (ADD..LUI = 0..10) and the op-vector width 11;
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - XLEN from E203_XLEN.
- One sub-module, ex_alu_dpath_seq_comb: purely combinational 1-cycle ops (add, sub, xor, or, and, slt, sltu, lui) plus the one-hot legality check. The top holds the FSM, the shift accumulator/counter and the result register.

Test Plan:
- add: op1=32'h7FFF_FFFF, op2=1, rsp_ready=1 -> rsp_valid 1 cycle after accept, rsp_res=32'h8000_0000, rsp_err=0. sub with 0 and 1 -> 32'hFFFF_FFFF.
- sra: op1=32'h8000_0010, op2=32'h0000_0024 (shamt=4) -> rsp_valid 5 cycles after accept, rsp_res=32'hF800_0001. sll with shamt=0 -> 1-cycle latency, rsp_res=op1.
- slt vs sltu: op1=32'hFFFF_FFFF, op2=1 -> slt res=1, sltu res=0.
- Backpressure: complete srl (op1=32'hF0, shamt=4), hold rsp_ready=0 for 6 cycles -> rsp_valid and rsp_res=32'hF held stable, req_ready=0, a new req_valid is ignored. Raise rsp_ready -> IDLE next cycle.
- Illegal op: req_op=11'b000_0000_0011 -> rsp_err=1, rsp_res=0 after 1 cycle. req_op=0 gives the same.
- Reset mid-shift: sll with shamt=31, assert rst at cycle 10 -> no rsp_valid ever for that op. After rst drops, req_ready=1, and a new add of 2+3 returns 5.
